// File: rtl/bnn_pkg.sv
// Shared constants, state encoding and debug view for the host side of the BNN link.
package bnn_pkg;

    localparam int IMG_BITS       = 904;
    localparam int IMG_BYTES      = IMG_BITS / 8;
    localparam int ENABLE_HOLD    = 4;
    localparam int RESULT_TIMEOUT = 4096;

    localparam int CNT_W  = 7;
    localparam int HOLD_W = 3;
    localparam int WAIT_W = $clog2(RESULT_TIMEOUT);

    localparam logic [7:0]        TIMEOUT_BYTE = 8'hEE;
    localparam logic [CNT_W-1:0]  LAST_BYTE    = CNT_W'(IMG_BYTES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(ENABLE_HOLD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(RESULT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        FULL  = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        CLEAR = 3'd4
    } host_state_t;

    typedef struct packed {
        host_state_t       state;
        logic [CNT_W-1:0]  byte_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [WAIT_W-1:0] wait_cnt;
    } host_dbg_t;

    // The digit travels in the low nibble; values above 9 are not filtered.
    function automatic logic [7:0] result_byte(input logic [3:0] digit);
        return {4'h0, digit};
    endfunction

endpackage

// File: rtl/img_byte_assembler.sv
// Byte-serial image assembler: shifts bytes in MSB-first and flags the final byte of an image.
module img_byte_assembler
    import bnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic                freeze,
    input  logic [7:0]          byte_in,
    output logic [IMG_BITS-1:0] img,
    output logic [CNT_W-1:0]    count,
    output logic                done
);

    logic take;

    assign take = load & ~freeze & ~clear;
    assign done = take & (count == LAST_BYTE);

    // IMG_BITS is an exact multiple of 8, so after IMG_BYTES shifts the first byte sits at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img   <= '0;
            count <= '0;
        end else if (clear) begin
            img   <= '0;
            count <= '0;
        end else if (take) begin
            img   <= {img[IMG_BITS-9:0], byte_in};
            count <= done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bnn_host_ctrl.sv
// Host controller: gathers an image from the byte link, starts the BNN, returns the digit and re-arms.
module bnn_host_ctrl
    import bnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                soft_clear,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic                bnn_enable,
    output logic                bnn_clear,
    input  logic [3:0]          result_in,
    input  logic                result_ready_in,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                timeout_err,
    output host_dbg_t           dbg
);

    // rx and tx are valid/ready links: a transfer occurs on a clock edge where both are high,
    // and the source keeps its data stable from raising valid until that edge.

    host_state_t       state, next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        tx_reg;
    logic              timeout_q;
    logic              accept;
    logic              img_done;
    logic              result_hit;
    logic              timeout_hit;

    assign accept = rx_valid & rx_ready;

    img_byte_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (soft_clear),
        .load    (accept),
        .freeze  (state != LOAD),
        .byte_in (rx_byte),
        .img     (img_out),
        .count   (byte_cnt),
        .done    (img_done)
    );

    // A result level still high from the previous image is ignored on the first WAIT cycle.
    assign result_hit  = (state == WAIT) && result_ready_in && (wait_cnt != '0);
    assign timeout_hit = (state == WAIT) && !result_hit && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (soft_clear) begin
            next_state = CLEAR;
        end else begin
            case (state)
                LOAD:    if (img_done)              next_state = FULL;
                FULL:    if (hold_cnt == HOLD_LAST) next_state = WAIT;
                WAIT:    if (result_hit || timeout_hit) next_state = SEND;
                SEND:    if (tx_ready)              next_state = CLEAR;
                CLEAR:                              next_state = LOAD;
                default:                            next_state = LOAD;
            endcase
        end
    end

    // rx_ready is qualified by rst_n so every output reads 0 while reset is held.
    always_comb begin
        rx_ready        = 1'b0;
        img_buffer_full = 1'b0;
        bnn_enable      = 1'b0;
        bnn_clear       = 1'b0;
        tx_valid        = 1'b0;
        busy            = 1'b1;
        case (state)
            LOAD: begin
                rx_ready = rst_n & ~soft_clear;
                busy     = 1'b0;
            end
            FULL: begin
                img_buffer_full = 1'b1;
                bnn_enable      = 1'b1;
            end
            SEND:    tx_valid  = 1'b1;
            CLEAR:   bnn_clear = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            hold_cnt <= (state == FULL && next_state == FULL) ? hold_cnt + HOLD_W'(1) : '0;
            wait_cnt <= (state == WAIT && next_state == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

    // When a result and the timeout coincide, result_hit masks timeout_hit, so no error is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg    <= '0;
            timeout_q <= 1'b0;
        end else if (soft_clear) begin
            timeout_q <= 1'b0;
        end else if (result_hit) begin
            tx_reg <= result_byte(result_in);
        end else if (timeout_hit) begin
            tx_reg    <= TIMEOUT_BYTE;
            timeout_q <= 1'b1;
        end
    end

    assign tx_byte     = tx_reg;
    assign timeout_err = timeout_q;

    assign dbg.state    = state;
    assign dbg.byte_cnt = byte_cnt;
    assign dbg.hold_cnt = hold_cnt;
    assign dbg.wait_cnt = wait_cnt;

endmodule
